uncache_handler: RTL and testbench

//  Uncached-access engine of the LSU. Sits downstream of the write buffer (WBUFFER2UHANDLER) and read buffer
//  (RBUFFER2UHANDLER), upstream of the memory bus (UNCACHE2MEMORY). Runs one uncached store or load at a time,

---
 rtl/uncache_handler_pkg.sv | 36 +++
 rtl/uncache_handler_if.sv | 51 +++++
 rtl/uncache_lane_align.sv | 38 +++
 rtl/uncache_handler.sv | 138 +++++++++++++
 tb/tb_uncache_handler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uncache_handler_pkg.sv
// Shared LSU types for the uncached-access engine: access sizes, handler states,
// bus size codes and the byte-strobe helper.
package uncache_handler_pkg;

    typedef enum logic [1:0] {
        s_nil  = 2'd0,
        s_byte = 2'd1,
        s_half = 2'd2,
        s_word = 2'd3
    } Size;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } uh_state_t;

    localparam logic [2:0] USIZE_BYTE = 3'b000;
    localparam logic [2:0] USIZE_HALF = 3'b001;
    localparam logic [2:0] USIZE_WORD = 3'b010;

    // Halfwords ignore addr[0]; a misaligned half is trapped before it gets here.
    function automatic logic [3:0] size2strobe(input Size size, input logic [1:0] addr);
        logic [3:0] strobe;
        strobe = 4'b0000;
        case (size)
            s_byte:  strobe = 4'b0001 << addr;
            s_half:  strobe = 4'b0011 << {addr[1], 1'b0};
            s_word:  strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/uncache_handler_if.sv
// Request/response bundle between the write/read buffers, the uncached handler
// and the memory bus. The handler takes the master view, its environment the slave view.
interface uncache_handler_if
    import uncache_handler_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              w;
    logic [ADDR_W-1:0] waddr;
    Size               wsize;
    logic [DATA_W-1:0] wdata;
    logic              wready;

    logic              rvalid;
    logic [ADDR_W-1:0] raddr;
    Size               rsize;
    logic              rready;
    logic              uready;
    logic              uvalid;
    logic [DATA_W-1:0] udata;

    logic              m_uvalid;
    logic              m_uwen;
    logic [ADDR_W-1:0] m_uaddr;
    logic [DATA_W-1:0] m_udata;
    logic [3:0]        m_ustrobe;
    logic [2:0]        m_usize;
    logic              m_uready;
    logic              m_mready;
    logic              m_mvalid;
    logic [DATA_W-1:0] m_mdata;

    modport master (
        input  w, waddr, wsize, wdata,
        input  rvalid, raddr, rsize, rready,
        input  m_mready, m_mvalid, m_mdata,
        output wready, uready, uvalid, udata,
        output m_uvalid, m_uwen, m_uaddr, m_udata, m_ustrobe, m_usize, m_uready
    );

    modport slave (
        output w, waddr, wsize, wdata,
        output rvalid, raddr, rsize, rready,
        output m_mready, m_mvalid, m_mdata,
        input  wready, uready, uvalid, udata,
        input  m_uvalid, m_uwen, m_uaddr, m_udata, m_ustrobe, m_usize, m_uready
    );

endinterface

// File: rtl/uncache_lane_align.sv
// Combinational lane steering: moves right-aligned store data onto its byte lanes
// and derives the bus byte enables and size code from the access size and address.
module uncache_lane_align
    import uncache_handler_pkg::*;
(
    input  Size         size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] lane_data,
    output logic [3:0]  strobe,
    output logic [2:0]  usize
);

    always_comb begin
        lane_data = 32'd0;
        usize     = USIZE_BYTE;
        strobe    = size2strobe(size, addr);
        case (size)
            s_byte: begin
                lane_data = {24'd0, wdata[7:0]} << {addr, 3'b000};
                usize     = USIZE_BYTE;
            end
            s_half: begin
                lane_data = {16'd0, wdata[15:0]} << {addr[1], 4'b0000};
                usize     = USIZE_HALF;
            end
            s_word: begin
                lane_data = wdata;
                usize     = USIZE_WORD;
            end
            default: begin
                lane_data = 32'd0;
                usize     = USIZE_BYTE;
            end
        endcase
    end

endmodule

// File: rtl/uncache_handler.sv
// Uncached-access engine: runs one uncached store or load at a time on the memory bus.
// Define UHANDLER_RR_ARB_EN for round-robin store/load arbitration (default: store first).
module uncache_handler
    import uncache_handler_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               resetn,
    uncache_handler_if.master uif
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_RESP = RESP;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    Size               size_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              wen_reg;
    logic [DATA_W-1:0] udata_reg;
    logic              wready_reg;
    logic              uready_reg;

    logic w_req;
    logic r_req;
    logic grant_w;
    logic grant_r;

    // The store stays asserted during its wready cycle; masking it avoids replaying it.
    assign w_req   = uif.w & ~wready_reg;
    assign r_req   = uif.rvalid;
    assign grant_r = r_req & ~grant_w;

`ifdef UHANDLER_RR_ARB_EN
    logic load_first_reg;

    assign grant_w = w_req & (~r_req | ~load_first_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_first_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && w_req && r_req) begin
            load_first_reg <= ~load_first_reg;
        end
    end
`else
    assign grant_w = w_req;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            size_reg   <= s_nil;
            wdata_reg  <= '0;
            wen_reg    <= 1'b0;
            udata_reg  <= '0;
            wready_reg <= 1'b0;
            uready_reg <= 1'b0;
        end else begin
            wready_reg <= 1'b0;
            uready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_w) begin
                        addr_reg  <= uif.waddr;
                        size_reg  <= uif.wsize;
                        wdata_reg <= uif.wdata;
                        wen_reg   <= 1'b1;
                        if (uif.wsize == s_nil) begin
                            wready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_REQ;
                        end
                    end else if (grant_r) begin
                        addr_reg   <= uif.raddr;
                        size_reg   <= uif.rsize;
                        wdata_reg  <= '0;
                        wen_reg    <= 1'b0;
                        uready_reg <= 1'b1;
                        if (uif.rsize == s_nil) begin
                            udata_reg <= '0;
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (uif.m_mready) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (uif.m_mvalid) begin
                        if (wen_reg) begin
                            wready_reg <= 1'b1;
                            state_reg  <= ST_IDLE;
                        end else begin
                            udata_reg <= uif.m_mdata;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (uif.rready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    uncache_lane_align u_lane_align (
        .size      (size_reg),
        .addr      (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .lane_data (uif.m_udata),
        .strobe    (uif.m_ustrobe),
        .usize     (uif.m_usize)
    );

    // Handshake outputs decode straight from the state register so reset clears them at once.
    assign uif.m_uvalid = (state_reg == ST_REQ);
    assign uif.m_uready = (state_reg == ST_RESP);
    assign uif.uvalid   = (state_reg == ST_DONE);
    assign uif.m_uwen   = wen_reg;
    assign uif.m_uaddr  = addr_reg;
    assign uif.udata    = udata_reg;
    assign uif.wready   = wready_reg;
    assign uif.uready   = uready_reg;

endmodule

// File: tb/tb_uncache_handler.sv
// Self-checking bench for uncache_handler: directed spec scenarios plus random
// stores/loads checked against a byte-lane reference model and a reactive bus/buffer model.
module tb_uncache_handler;
    import uncache_handler_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int uready_seen = 0;
    int wready_seen = 0;
    int wready_cyc  = 0;

    uncache_handler_if #(.ADDR_W(32), .DATA_W(32)) uif ();

    uncache_handler #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .uif    (uif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before 400000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: which byte lanes an access covers and what lands on them.
    function automatic int nbytes(input Size s);
        case (s)
            s_byte:  return 1;
            s_half:  return 2;
            s_word:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int lane_off(input Size s, input logic [31:0] a);
        case (s)
            s_byte:  return int'(a % 4);
            s_half:  return (int'(a % 4) / 2) * 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_strobe(input Size s, input logic [31:0] a);
        logic [3:0] r;
        int off, n;
        r = 4'b0000;
        off = lane_off(s, a);
        n = nbytes(s);
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + n) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_data(input Size s, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int off, n;
        r = 32'd0;
        off = lane_off(s, a);
        n = nbytes(s);
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + n) r[8*b +: 8] = d[8*(b-off) +: 8];
        return r;
    endfunction

    function automatic logic [2:0] model_usize(input Size s);
        case (s)
            s_half:  return 3'd1;
            s_word:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [127:0] all_outs();
        return {19'd0, uif.wready, uif.uready, uif.uvalid, uif.udata, uif.m_uvalid, uif.m_uwen,
                uif.m_uaddr, uif.m_udata, uif.m_ustrobe, uif.m_usize, uif.m_uready};
    endfunction

    // One clock; the buffers drop their request as soon as they see the handler's pulse.
    task automatic step();
        @(negedge clk);
        if (uif.uready === 1'b1) begin
            uready_seen++;
            uif.rvalid = 1'b0;
        end
        if (uif.wready === 1'b1) begin
            wready_seen++;
            wready_cyc = cyc;
            uif.w = 1'b0;
        end
    endtask

    task automatic serve_bus(input string tag, input logic exp_wen, input logic [31:0] a, input Size s,
                             input logic [31:0] d, input int rdy_stall, input int rsp_stall,
                             input logic [31:0] rdata);
        int guard;
        logic [127:0] snap;
        guard = 0;
        while (uif.m_uvalid !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check({tag, "_req_valid"}, uif.m_uvalid, 1'b1);
        if (uif.m_uvalid !== 1'b1) return;
        check({tag, "_uwen"}, uif.m_uwen, exp_wen);
        check({tag, "_uaddr"}, uif.m_uaddr, a);
        check({tag, "_usize"}, uif.m_usize, model_usize(s));
        if (exp_wen) begin
            check({tag, "_strobe"}, uif.m_ustrobe, model_strobe(s, a));
            check({tag, "_udata"}, uif.m_udata, model_data(s, a, d));
        end
        snap = {55'd0, uif.m_uvalid, uif.m_uwen, uif.m_uaddr, uif.m_udata, uif.m_ustrobe, uif.m_usize};
        for (int k = 0; k < rdy_stall; k++) begin
            step();
            check({tag, "_stall_stable"},
                  {55'd0, uif.m_uvalid, uif.m_uwen, uif.m_uaddr, uif.m_udata, uif.m_ustrobe, uif.m_usize}, snap);
        end
        uif.m_mready = 1'b1;
        step();
        uif.m_mready = 1'b0;
        check({tag, "_resp_phase"}, {uif.m_uvalid, uif.m_uready}, 2'b01);
        for (int k = 0; k < rsp_stall; k++) begin
            step();
            check({tag, "_resp_wait"}, {uif.m_uready, uif.wready, uif.uvalid}, 3'b100);
        end
        uif.m_mvalid = 1'b1;
        uif.m_mdata  = rdata;
        step();
        uif.m_mvalid = 1'b0;
        uif.m_mdata  = $urandom;
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input Size s, input logic [31:0] d,
                            input int rdy_stall, input int rsp_stall);
        int t0, wr0;
        uif.w = 1'b1;
        uif.waddr = a;
        uif.wsize = s;
        uif.wdata = d;
        t0 = cyc;
        wr0 = wready_seen;
        if (s == s_nil) begin
            step();
            check({tag, "_nil_wready"}, uif.wready, 1'b1);
            check({tag, "_nil_no_bus"}, uif.m_uvalid, 1'b0);
        end else begin
            serve_bus(tag, 1'b1, a, s, d, rdy_stall, rsp_stall, $urandom);
            check({tag, "_wready"}, uif.wready, 1'b1);
            if (rdy_stall == 0 && rsp_stall == 0) check({tag, "_latency"}, wready_cyc - t0, 3);
        end
        step();
        check({tag, "_wready_pulse"}, {uif.wready, uif.m_uvalid}, 2'b00);
        check({tag, "_wready_count"}, wready_seen - wr0, 1);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input Size s, input logic [31:0] rdata,
                           input int rdy_stall, input int rsp_stall, input int hold);
        int t0, ur0;
        logic [31:0] exp_data;
        uif.rvalid = 1'b1;
        uif.raddr = a;
        uif.rsize = s;
        t0 = cyc;
        ur0 = uready_seen;
        exp_data = (s == s_nil) ? 32'd0 : rdata;
        if (s == s_nil) begin
            step();
            check({tag, "_nil_no_bus"}, uif.m_uvalid, 1'b0);
            check({tag, "_nil_latency"}, cyc - t0, 1);
        end else begin
            serve_bus(tag, 1'b0, a, s, 32'd0, rdy_stall, rsp_stall, rdata);
            if (rdy_stall == 0 && rsp_stall == 0) check({tag, "_latency"}, cyc - t0, 3);
        end
        check({tag, "_uready_count"}, uready_seen - ur0, 1);
        check({tag, "_uvalid"}, uif.uvalid, 1'b1);
        check({tag, "_udata"}, uif.udata, exp_data);
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, "_hold"}, {uif.uvalid, uif.udata}, {1'b1, exp_data});
        end
        uif.rready = 1'b1;
        step();
        uif.rready = 1'b0;
        check({tag, "_released"}, uif.uvalid, 1'b0);
    endtask

    task automatic collide(input string tag, input logic load_first);
        logic [31:0] wa, wd, ra, rd;
        int wr0, ur0;
        wa = {$urandom} & 32'hFFFF_FFFC;
        wd = $urandom;
        ra = {$urandom} & 32'hFFFF_FFFC;
        rd = $urandom;
        uif.w = 1'b1;  uif.waddr = wa; uif.wsize = s_word; uif.wdata = wd;
        uif.rvalid = 1'b1; uif.raddr = ra; uif.rsize = s_word;
        wr0 = wready_seen;
        ur0 = uready_seen;
        if (!load_first) begin
            serve_bus({tag, "_st"}, 1'b1, wa, s_word, wd, 0, 0, $urandom);
            check({tag, "_st_done"}, {wready_seen - wr0, uready_seen - ur0}, {32'd1, 32'd0});
            serve_bus({tag, "_ld"}, 1'b0, ra, s_word, 32'd0, 0, 0, rd);
            check({tag, "_ld_data"}, {uif.uvalid, uif.udata}, {1'b1, rd});
            uif.rready = 1'b1;
            step();
            uif.rready = 1'b0;
        end else begin
            serve_bus({tag, "_ld"}, 1'b0, ra, s_word, 32'd0, 0, 0, rd);
            check({tag, "_ld_data"}, {uif.uvalid, uif.udata}, {1'b1, rd});
            check({tag, "_ld_done"}, {wready_seen - wr0, uready_seen - ur0}, {32'd0, 32'd1});
            uif.rready = 1'b1;
            step();
            uif.rready = 1'b0;
            serve_bus({tag, "_st"}, 1'b1, wa, s_word, wd, 0, 0, $urandom);
            step();
        end
        check({tag, "_both_done"}, {wready_seen - wr0, uready_seen - ur0, 1'b0, uif.uvalid},
              {32'd1, 32'd1, 2'b00});
    endtask

    initial begin
        logic [31:0] ra;
        Size rs;
        int guard;

        uif.w = 1'b0;  uif.waddr = '0; uif.wsize = s_nil; uif.wdata = '0;
        uif.rvalid = 1'b0; uif.raddr = '0; uif.rsize = s_nil; uif.rready = 1'b0;
        uif.m_mready = 1'b0; uif.m_mvalid = 1'b0; uif.m_mdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'd0);
        resetn = 1'b1;
        step();
        check("idle_after_reset", all_outs(), 128'd0);

        // Directed scenarios
        do_store("t1_store_byte", 32'h1FC0_0003, s_byte, 32'h0000_00A5, 0, 0);
        do_load("t2_load_word", 32'h1FD0_0010, s_word, 32'hDEAD_BEEF, 0, 4, 3);
        do_store("t4_mready_stall", 32'h1FC0_1004, s_word, 32'h0BAD_F00D, 5, 0);
        do_store("t5_store_half", 32'h1FC0_0002, s_half, 32'h0000_1234, 0, 0);
        do_store("t5_store_nil", 32'h1FC0_0008, s_nil, 32'hFFFF_FFFF, 0, 0);
        do_load("t5_load_nil", 32'h1FD0_0020, s_nil, 32'h5555_5555, 0, 0, 1);
        do_load("t5_load_half", 32'h1FD0_0006, s_half, 32'hCAFE_0123, 2, 1, 0);

        // Collisions: store wins the first; round-robin hands the second to the load
        collide("t3_collide1", 1'b0);
`ifdef UHANDLER_RR_ARB_EN
        collide("t3_collide2", 1'b1);
`else
        collide("t3_collide2", 1'b0);
`endif

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            rs = Size'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_store("rnd_store", $urandom, rs, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_load("rnd_load", $urandom, rs, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3));
        end

        // Reset while waiting for the bus response
        ra = 32'h1FD0_0040;
        uif.rvalid = 1'b1; uif.raddr = ra; uif.rsize = s_word;
        guard = 0;
        while (uif.m_uvalid !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check("t6_req_valid", uif.m_uvalid, 1'b1);
        uif.m_mready = 1'b1;
        step();
        uif.m_mready = 1'b0;
        check("t6_in_resp", uif.m_uready, 1'b1);
        #2 resetn = 1'b0;
        #1 check("t6_async_reset", all_outs(), 128'd0);
        step();
        step();
        check("t6_held_in_reset", all_outs(), 128'd0);
        resetn = 1'b1;
        do_load("t6_fresh_load", 32'h1FD0_0044, s_word, 32'h1357_9BDF, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
